// File: rtl/decode_pkg.sv
// Shared opcode, mux-select and bubble constants for the decode stage and its fetch-side muxes.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [1:0] PCSEL_Z4   = 2'd0;
  localparam logic [1:0] PCSEL_INC  = 2'd1;
  localparam logic [1:0] PCSEL_HOLD = 2'd2;
  localparam logic [1:0] PCSEL_BR   = 2'd3;

  localparam logic [1:0] IRSEL_MEM  = 2'd0;
  localparam logic [1:0] IRSEL_NOP  = 2'd1;
  localparam logic [1:0] IRSEL_HOLD = 2'd2;

  localparam logic [31:0] NOP_WORD = 32'h0000_0001;

  // Destination register of an instruction word; 0 means "writes nothing".
  function automatic logic [4:0] dest_of(input logic [31:0] ir);
    logic [4:0] d;
    d = 5'd0;
    if (ir != NOP_WORD) begin
      case (ir[31:26])
        OP_RTYPE:      d = ir[15:11];
        OP_ADDI, OP_LW: d = ir[20:16];
        default:       d = 5'd0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/decode_stage_register_file.sv
// 32x32 register file: two combinational read ports with write-through bypass, r0 hardwired to zero.
module register_file
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  raddr_a,
  output logic [31:0] rdata_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_b,
  input  logic        wen,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  always_comb begin
    regs_d = regs_q;
    if (wen && (waddr != 5'd0)) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) regs_q <= '{default: '0};
    else       regs_q <= regs_d;
  end

  always_comb begin
    rdata_a = regs_q[raddr_a];
    if (raddr_a == 5'd0)                    rdata_a = '0;
    else if (wen && (waddr == raddr_a))     rdata_a = wdata;
    rdata_b = regs_q[raddr_b];
    if (raddr_b == 5'd0)                    rdata_b = '0;
    else if (wen && (waddr == raddr_b))     rdata_b = wdata;
  end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode: register read, in-stage BEQ resolution, hazard stalls, fetch mux selects, ID/EX latches.
module decode_stage #(
  parameter logic [31:0] NOP_WORD = decode_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir2,
  input  logic [31:0] pc2,
  input  logic        wb_wen,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_wdata,
  input  logic        mem_wen,
  input  logic [4:0]  mem_waddr,
  output logic [1:0]  pc_sel,
  output logic [1:0]  ir_sel,
  output logic        pc2_sel,
  output logic [31:0] branch_target,
  output logic [31:0] ir3,
  output logic [31:0] pc3,
  output logic [31:0] a3,
  output logic [31:0] b3,
  output logic [31:0] imm3
);
  import decode_pkg::*;

  logic [5:0]  opc2;
  logic [4:0]  rs2, rt2, dest3;
  logic [31:0] imm2_sext, rs_val, rt_val;
  logic        uses_rs, uses_rt, is_beq2, load_use, br_stall, stall, taken;
  logic [31:0] ir3_q, pc3_q, a3_q, b3_q, imm3_q;
  logic [31:0] ir3_d, pc3_d, a3_d, b3_d, imm3_d;

  assign opc2      = ir2[31:26];
  assign rs2       = ir2[25:21];
  assign rt2       = ir2[20:16];
  assign imm2_sext = {{16{ir2[15]}}, ir2[15:0]};
  assign dest3     = dest_of(ir3_q);

  register_file u_rf (
    .clk     (clk),
    .reset   (reset),
    .raddr_a (rs2),
    .rdata_a (rs_val),
    .raddr_b (rt2),
    .rdata_b (rt_val),
    .wen     (wb_wen),
    .waddr   (wb_waddr),
    .wdata   (wb_wdata)
  );

  always_comb begin
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    if (ir2 != NOP_WORD) begin
      case (opc2)
        OP_RTYPE, OP_SW, OP_BEQ: begin uses_rs = 1'b1; uses_rt = 1'b1; end
        OP_ADDI, OP_LW:          uses_rs = 1'b1;
        default:                 ;
      endcase
    end
    is_beq2 = (ir2 != NOP_WORD) && (opc2 == OP_BEQ);

    load_use = (ir3_q != NOP_WORD) && (ir3_q[31:26] == OP_LW) && (ir3_q[20:16] != 5'd0) &&
               ((uses_rs && (ir3_q[20:16] == rs2)) || (uses_rt && (ir3_q[20:16] == rt2)));

    // BEQ compares in this stage, so any in-flight producer of its operands must drain first.
    br_stall = is_beq2 &&
               (((rs2 != 5'd0) && ((rs2 == dest3) || (mem_wen && (rs2 == mem_waddr)))) ||
                ((rt2 != 5'd0) && ((rt2 == dest3) || (mem_wen && (rt2 == mem_waddr)))));

    stall = load_use || br_stall;
    taken = is_beq2 && !stall && (rs_val == rt_val);

    if (reset) begin
      pc_sel = PCSEL_Z4;   ir_sel = IRSEL_NOP;  pc2_sel = 1'b0;
    end else if (stall) begin
      pc_sel = PCSEL_HOLD; ir_sel = IRSEL_HOLD; pc2_sel = 1'b1;
    end else if (taken) begin
      pc_sel = PCSEL_BR;   ir_sel = IRSEL_NOP;  pc2_sel = 1'b0;
    end else begin
      pc_sel = PCSEL_INC;  ir_sel = IRSEL_MEM;  pc2_sel = 1'b0;
    end

    branch_target = pc2 + {imm2_sext[29:0], 2'b00};

    if (stall) begin
      ir3_d = NOP_WORD; pc3_d = pc2; a3_d = '0; b3_d = '0; imm3_d = '0;
    end else begin
      ir3_d = ir2; pc3_d = pc2; a3_d = rs_val; b3_d = rt_val; imm3_d = imm2_sext;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir3_q  <= NOP_WORD;
      pc3_q  <= '0;
      a3_q   <= '0;
      b3_q   <= '0;
      imm3_q <= '0;
    end else begin
      ir3_q  <= ir3_d;
      pc3_q  <= pc3_d;
      a3_q   <= a3_d;
      b3_q   <= b3_d;
      imm3_q <= imm3_d;
    end
  end

  assign ir3  = ir3_q;
  assign pc3  = pc3_q;
  assign a3   = a3_q;
  assign b3   = b3_q;
  assign imm3 = imm3_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: bypass, r0, load-use, branch resolve/stall and async reset.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir2, pc2, wb_wdata;
  logic        wb_wen, mem_wen;
  logic [4:0]  wb_waddr, mem_waddr;
  logic [1:0]  pc_sel, ir_sel;
  logic        pc2_sel;
  logic [31:0] branch_target, ir3, pc3, a3, b3, imm3;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] NOP = 32'h0000_0001;

  decode_stage dut (
    .clk           (clk),
    .reset         (reset),
    .ir2           (ir2),
    .pc2           (pc2),
    .wb_wen        (wb_wen),
    .wb_waddr      (wb_waddr),
    .wb_wdata      (wb_wdata),
    .mem_wen       (mem_wen),
    .mem_waddr     (mem_waddr),
    .pc_sel        (pc_sel),
    .ir_sel        (ir_sel),
    .pc2_sel       (pc2_sel),
    .branch_target (branch_target),
    .ir3           (ir3),
    .pc3           (pc3),
    .a3            (a3),
    .b3            (b3),
    .imm3          (imm3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 11'h020};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic sel_chk(input string tag, input logic [1:0] p, input logic [1:0] i, input logic p2);
    chk({tag, ".pc_sel"},  {30'd0, pc_sel}, {30'd0, p});
    chk({tag, ".ir_sel"},  {30'd0, ir_sel}, {30'd0, i});
    chk({tag, ".pc2_sel"}, {31'd0, pc2_sel}, {31'd0, p2});
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    ir2 = NOP; wb_wen = 1'b1; wb_waddr = a; wb_wdata = d;
    step();
    wb_wen = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ir2 = NOP; pc2 = 32'h0; wb_wen = 1'b0; wb_waddr = '0; wb_wdata = '0;
    mem_wen = 1'b0; mem_waddr = '0;
    repeat (3) @(posedge clk);
    #1;
    sel_chk("reset", 2'd0, 2'd1, 1'b0);
    chk("reset.ir3", ir3, NOP);
    chk("reset.a3", a3, 32'h0);
    chk("reset.b3", b3, 32'h0);

    reset = 1'b0;
    #1;
    sel_chk("idle", 2'd1, 2'd0, 1'b0);

    // Bypass: write r5 in the same cycle ADD reads it
    ir2 = rtype(5'd5, 5'd0, 5'd6); pc2 = 32'h40;
    wb_wen = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'hDEAD_BEEF;
    step();
    wb_wen = 1'b0;
    chk("bypass.a3", a3, 32'hDEAD_BEEF);
    chk("bypass.ir3", ir3, rtype(5'd5, 5'd0, 5'd6));
    chk("bypass.pc3", pc3, 32'h40);

    ir2 = rtype(5'd5, 5'd5, 5'd6);
    step();
    chk("stored.a3", a3, 32'hDEAD_BEEF);
    chk("stored.b3", b3, 32'hDEAD_BEEF);

    // r0 write must neither bypass nor stick
    ir2 = rtype(5'd0, 5'd0, 5'd1);
    wb_wen = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'h1234_5678;
    step();
    wb_wen = 1'b0;
    chk("r0.bypass", a3, 32'h0);
    step();
    chk("r0.read", a3, 32'h0);

    ir2 = itype(6'h08, 5'd0, 5'd9, 16'hFFF0);
    step();
    chk("addi.imm3", imm3, 32'hFFFF_FFF0);

    // Load-use on r3
    ir2 = itype(6'h23, 5'd0, 5'd3, 16'h0004); pc2 = 32'h50;
    step();
    chk("lw.imm3", imm3, 32'h4);
    ir2 = rtype(5'd3, 5'd0, 5'd7); pc2 = 32'h54;
    #1;
    sel_chk("lduse", 2'd2, 2'd2, 1'b1);
    step();
    chk("lduse.ir3", ir3, NOP);
    chk("lduse.imm3", imm3, 32'h0);
    chk("lduse.pc3", pc3, 32'h54);
    sel_chk("lduse.after", 2'd1, 2'd0, 1'b0);
    step();
    chk("lduse.issue", ir3, rtype(5'd3, 5'd0, 5'd7));

    // BEQ taken with negative offset, plus not-taken and wrap
    wb_write(5'd1, 32'd7);
    wb_write(5'd2, 32'd7);
    ir2 = itype(6'h04, 5'd1, 5'd2, 16'hFFFE); pc2 = 32'h100;
    #1;
    sel_chk("beq.taken", 2'd3, 2'd1, 1'b0);
    chk("beq.target", branch_target, 32'h0000_00F8);
    ir2 = itype(6'h04, 5'd1, 5'd5, 16'h0010);
    #1;
    sel_chk("beq.nottaken", 2'd1, 2'd0, 1'b0);
    ir2 = itype(6'h04, 5'd1, 5'd5, 16'h0002); pc2 = 32'hFFFF_FFFC;
    #1;
    chk("beq.wrap", branch_target, 32'h0000_0004);

    // BEQ operand produced by instruction in MEM
    ir2 = itype(6'h04, 5'd4, 5'd4, 16'h0001); pc2 = 32'h200;
    mem_wen = 1'b1; mem_waddr = 5'd4;
    #1;
    sel_chk("beq.memstall", 2'd2, 2'd2, 1'b1);
    mem_wen = 1'b0;
    #1;
    sel_chk("beq.memclear", 2'd3, 2'd1, 1'b0);

    // BEQ operand produced by ALU instruction in ir3, then async reset mid-stall
    ir2 = itype(6'h08, 5'd0, 5'd4, 16'h0009); pc2 = 32'h300;
    step();
    ir2 = itype(6'h04, 5'd4, 5'd0, 16'h0001); pc2 = 32'h304;
    #1;
    sel_chk("beq.exstall", 2'd2, 2'd2, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    sel_chk("midreset", 2'd0, 2'd1, 1'b0);
    chk("midreset.ir3", ir3, NOP);
    chk("midreset.pc3", pc3, 32'h0);
    chk("midreset.imm3", imm3, 32'h0);
    step();
    reset = 1'b0;
    ir2 = rtype(5'd5, 5'd0, 5'd6); pc2 = 32'h0;
    step();
    chk("midreset.rfclear", a3, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Second pipeline stage. It consumes the IR2/PC2 latches from instruction fetch and decodes the instruction. It reads a 32×32 register file with write-back bypass, resolves BEQ in-stage, and detects load-use and branch-operand hazards. It drives the fetch-stage mux selects and latches IR3/PC3/A3/B3/IMM3 for execute.

## Interface
Parameters:
- NOP_WORD, 32'h0000_0001, bubble encoding; matches the fetch-stage nop constant.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high.
- ir2  input  32  instruction from fetch IR2 latch.
- pc2  input  32  PC+4 of the instruction in ir2.
- wb_wen  input  1  write-back enable.
- wb_waddr  input  5  write-back destination.
- wb_wdata  input  32  write-back data.
- mem_wen  input  1  instruction in MEM stage will write a register.
- mem_waddr  input  5  its destination.
- pc_sel  output  2  fetch PC mux: 0 = start vector z4, 1 = PC+4, 2 = hold, 3 = branch target.
- ir_sel  output  2  fetch IR2 mux: 0 = memory, 1 = NOP, 2 = hold.
- pc2_sel  output  1  fetch PC2 mux: 0 = PC+4, 1 = hold.
- branch_target  output  32  pc2 + (sext(imm16) << 2).
- ir3, pc3, a3, b3, imm3  output  32 each  ID/EX latches.

## Operation
- Field decode: opcode = ir2[31:26], rs = [25:21], rt = [20:16], rd = [15:11], imm16 = [15:0].
- Opcode classes: R-type 6'h00 (dest rd); ADDI 6'h08 and LW 6'h23 (dest rt); SW 6'h2B and BEQ 6'h04 (no dest).
- NOP_WORD and all unknown opcodes are treated as no-dest and no-source.
- Register file: r0 reads 0 and ignores writes. Writes occur on posedge when wb_wen is high. A read whose address equals wb_waddr (non-zero) with wb_wen high returns wb_wdata in the same cycle.
- Load-use stall: ir3 is LW and its rt (non-zero) equals rs, or rt for R-type/SW/BEQ.
- Branch stall: ir2 is BEQ and either rs or rt (non-zero) matches:
  - the destination of ir3, or
  - mem_waddr with mem_wen high.
- Stall response: pc_sel=2, ir_sel=2, pc2_sel=1. Next edge: ir3 <= NOP_WORD; a3, b3, imm3 <= 0; pc3 <= pc2.
- Branch taken: ir2 is BEQ, no stall, rs value == rt value (after bypass). Response: pc_sel=3, ir_sel=1 (squash the wrong-path fetch), pc2_sel=0.
- BEQ not taken, or any other non-stalled instruction: pc_sel=1, ir_sel=0, pc2_sel=0. Latches load the decoded values: ir3 <= ir2, pc3 <= pc2, a3 <= rs value, b3 <= rt value, imm3 <= sext(imm16).
- Priority: reset > stall > branch taken > normal.

## Timing
- Select outputs and branch_target are combinational from ir2, ir3, pc2, the register file, and the mem/wb ports. They are valid before the same rising edge that fetch uses.
- While reset is high, select outputs are forced to pc_sel=0, ir_sel=1, pc2_sel=0, so fetch loads z4 and fills IR2 with NOP.
- Reset (async) values: ir3 = NOP_WORD; pc3, a3, b3, imm3 = 0; all 32 registers = 0.
- Decode-to-ID/EX latency: 1 cycle.
- Branch penalty: 1 squashed slot.
- Load-use penalty: 1 bubble.
- A BEQ behind an ALU producer costs 2 bubbles: one for the ir3 match, one for the MEM match.
- Simultaneous WB write and read of the same register returns the new data.
- A WB write to r0 has no effect.
- Reset asserted mid-stall: all latches clear immediately; no held state survives.
- branch_target wraps modulo 2^32.

## Structure
- Shared package decode_pkg holds:
  - opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ);
  - select encodings (PCSEL_Z4, PCSEL_INC, PCSEL_HOLD, PCSEL_BR, IRSEL_MEM, IRSEL_NOP, IRSEL_HOLD);
  - NOP_WORD.
- One sub-module, register_file: 2 combinational read ports, 1 synchronous write port, r0 hardwired, write-through bypass, async reset.
- Hazard/select logic and the ID/EX latches live in decode_stage.

## Test plan
- Reset held for 3 cycles: pc_sel=0, ir_sel=1, ir3=32'h1, a3=b3=0. After release with ir2=NOP, pc_sel=1.
- WB writes r5=32'hDEAD_BEEF while ir2 = R-type with rs=5: a3=32'hDEAD_BEEF on the next edge (bypass). A write to r0 followed by a read of r0 gives 0.
- ir3 = LW rt=3 and ir2 = ADD rs=3: one cycle with pc_sel=2, ir_sel=2, pc2_sel=1, then ir3=32'h1. Next cycle the ADD issues normally.
- BEQ r1,r2 with r1=r2=7, imm16=16'hFFFE, pc2=32'h100: pc_sel=3, branch_target=32'h0F8, ir_sel=1.
- BEQ r4,r4 with mem_wen=1, mem_waddr=4: stall asserted. After mem_wen drops, the branch resolves taken.
- Reset asserted during a stall cycle: all outputs return to reset values asynchronously, before the next edge.
